// File: rtl/alu_result_sequencer.sv
// alu_result_sequencer: captures the ALU result and serialises it as low/high beats onto the internal bus (optional one-hot check: ALU_RESULT_ONEHOT_CHECK_EN)
module alu_result_sequencer #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 12,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 capture_in,
    input  logic [SIG_COUNT-1:0] ctrl_signal,
    input  logic [2*BITS-1:0]    result_in,
    output logic                 in_ready,
    output logic [BITS-1:0]      bus_out,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic                 beat_high,
    output logic [BITS-1:0]      hi_out,
    output logic [BITS-1:0]      lo_out,
    output logic [CNT_BITS-1:0]  ops_done,
    output logic                 op_error
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    state_t              state;
    logic [2*BITS-1:0]   result_q;
    logic                wide_q;
    logic                wide;
    logic                ok;
    logic                last;
    logic                xfer;
    logic                cap;
    assign wide = ctrl_signal[2] | ctrl_signal[3];
`ifdef ALU_RESULT_ONEHOT_CHECK_EN
    assign ok = (ctrl_signal != '0) && ((ctrl_signal & (ctrl_signal - SIG_COUNT'(1))) == '0);
    // sticky flag for captures carrying a malformed op code
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            op_error <= 1'b0;
        else if (capture_in && in_ready && !ok)
            op_error <= 1'b1;
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = ^ctrl_signal;
    assign ok          = 1'b1;
    assign op_error    = 1'b0;
`endif
    assign bus_valid = state != IDLE;
    assign beat_high = state == HIGH;
    assign bus_out   = state == HIGH ? result_q[2*BITS-1:BITS] : state == LOW ? result_q[BITS-1:0] : '0;
    assign last      = state == HIGH || (state == LOW && !wide_q);
    assign xfer      = bus_valid && bus_ready;
    assign in_ready  = state == IDLE || (last && bus_ready);
    assign cap       = capture_in && in_ready && ok;
    // capture, beat sequencing, HI/LO latching and drained-result count
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            result_q <= '0;
            wide_q   <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            ops_done <= '0;
        end else begin
            if (cap) begin
                state    <= LOW;
                result_q <= result_in;
                wide_q   <= wide;
                if (wide) begin
                    hi_out <= result_in[2*BITS-1:BITS];
                    lo_out <= result_in[BITS-1:0];
                end
            end else if (xfer)
                state <= (state == LOW && wide_q) ? HIGH : IDLE;
            if (xfer && last)
                ops_done <= ops_done + CNT_BITS'(1);
        end
    end
endmodule

// File: tb/tb_alu_result_sequencer.sv
// tb_alu_result_sequencer: table-driven and scoreboard checks of the result sequencer
module tb_alu_result_sequencer;
    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        capture_in = 1'b0;
    logic [11:0] ctrl_signal = '0;
    logic [63:0] result_in = '0;
    logic        in_ready;
    logic [31:0] bus_out;
    logic        bus_valid;
    logic        bus_ready = 1'b1;
    logic        beat_high;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [7:0]  ops_done;
    logic        op_error;

    alu_result_sequencer dut (
        .clock(clk), .clear(clear), .capture_in(capture_in), .ctrl_signal(ctrl_signal),
        .result_in(result_in), .in_ready(in_ready), .bus_out(bus_out), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .beat_high(beat_high), .hi_out(hi_out), .lo_out(lo_out),
        .ops_done(ops_done), .op_error(op_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [11:0] ctrl; logic [63:0] res; int beats; } vec_t;
    typedef struct { logic [31:0] d; logic h; } beat_t;
    vec_t  tbl[5];
    beat_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;
    logic [7:0]  ops_m = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard: every beat accepted by the bus must match the next expected beat
    always @(negedge clk) begin
        if (!clear && bus_valid && bus_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got %h expected none", bus_out);
            end else begin
                beat_t b;
                b = q.pop_front();
                chk("beat_data", {32'h0, bus_out}, {32'h0, b.d});
                chk("beat_high", {63'h0, beat_high}, {63'h0, b.h});
            end
        end
    end

    task automatic do_cap(input logic [11:0] c, input logic [63:0] r, input int beats);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'h0, 64'h1);
        capture_in  = 1'b1;
        ctrl_signal = c;
        result_in   = r;
        q.push_back('{d: r[31:0], h: 1'b0});
        if (beats == 2) begin
            q.push_back('{d: r[63:32], h: 1'b1});
            hi_m = r[63:32];
            lo_m = r[31:0];
        end
        ops_m++;
        @(posedge clk);
        #1;
        capture_in = 1'b0;
        chk("hi_at_capture", {32'h0, hi_out}, {32'h0, hi_m});
        chk("lo_at_capture", {32'h0, lo_out}, {32'h0, lo_m});
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0 || bus_valid) chk("drain_timeout", 64'h0, 64'h1);
        chk("ops_done", {56'h0, ops_done}, {56'h0, ops_m});
    endtask

    initial begin
        tbl[0] = '{ctrl: 12'h001, res: 64'h0000_0000_0000_0007, beats: 1};
        tbl[1] = '{ctrl: 12'h004, res: 64'hDEAD_BEEF_1234_5678, beats: 2};
        tbl[2] = '{ctrl: 12'h008, res: 64'h0000_0003_0000_0011, beats: 2};
        tbl[3] = '{ctrl: 12'h002, res: 64'hFFFF_0000_AAAA_5555, beats: 1};
        tbl[4] = '{ctrl: 12'h800, res: 64'h1111_2222_3333_4444, beats: 1};
        #12;
        chk("rst_valid", {63'h0, bus_valid}, 64'h0);
        chk("rst_bus_out", {32'h0, bus_out}, 64'h0);
        chk("rst_hi", {32'h0, hi_out}, 64'h0);
        chk("rst_ops", {56'h0, ops_done}, 64'h0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            do_cap(tbl[i].ctrl, tbl[i].res, tbl[i].beats);
            chk("valid_after_capture", {63'h0, bus_valid}, 64'h1);
            drain();
        end
        // backpressure: divide held for 5 cycles, stray capture ignored
        bus_ready = 1'b0;
        do_cap(12'h008, 64'hCAFE_0001_BEEF_0002, 2);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {63'h0, bus_valid}, 64'h1);
            chk("stall_data", {32'h0, bus_out}, 64'hBEEF_0002);
            chk("stall_high", {63'h0, beat_high}, 64'h0);
            chk("stall_in_ready", {63'h0, in_ready}, 64'h0);
            capture_in  = (i == 2);
            ctrl_signal = 12'h004;
            result_in   = 64'h5555_5555_6666_6666;
            @(posedge clk);
            #1;
            capture_in = 1'b0;
        end
        chk("stall_hi_kept", {32'h0, hi_out}, {32'h0, hi_m});
        bus_ready = 1'b1;
        drain();
        // back-to-back: add captured on the multiply's HIGH transfer edge
        do_cap(12'h004, 64'h0BAD_F00D_0000_0042, 2);
        @(posedge clk);
        #1;
        chk("b2b_high_ready", {63'h0, in_ready}, 64'h1);
        chk("b2b_beat_high", {63'h0, beat_high}, 64'h1);
        do_cap(12'h001, 64'h0000_0000_0000_0099, 1);
        chk("b2b_valid", {63'h0, bus_valid}, 64'h1);
        chk("b2b_data", {32'h0, bus_out}, 64'h99);
        drain();
        // clear during a HIGH beat
        bus_ready = 1'b1;
        do_cap(12'h004, 64'h7777_8888_9999_AAAA, 2);
        @(posedge clk);
        #1;
        bus_ready = 1'b0;
        chk("pre_clear_high", {63'h0, beat_high}, 64'h1);
        #2;
        clear = 1'b1;
        #1;
        chk("clear_valid", {63'h0, bus_valid}, 64'h0);
        chk("clear_hi", {32'h0, hi_out}, 64'h0);
        chk("clear_ops", {56'h0, ops_done}, 64'h0);
        q.delete();
        hi_m  = '0;
        lo_m  = '0;
        ops_m = '0;
        @(negedge clk);
        clear     = 1'b0;
        bus_ready = 1'b1;
        @(posedge clk);
        #1;
        do_cap(12'h004, 64'h0123_4567_89AB_CDEF, 2);
        drain();
`ifdef ALU_RESULT_ONEHOT_CHECK_EN
        capture_in  = 1'b1;
        ctrl_signal = 12'h005;
        result_in   = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        capture_in = 1'b0;
        chk("bad_op_error", {63'h0, op_error}, 64'h1);
        chk("bad_op_valid", {63'h0, bus_valid}, 64'h0);
        chk("bad_op_hi", {32'h0, hi_out}, {32'h0, hi_m});
        do_cap(12'h001, 64'h5, 1);
        drain();
        chk("error_sticky", {63'h0, op_error}, 64'h1);
`else
        chk("op_error_tied", {63'h0, op_error}, 64'h0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_result_sequencer.md
Name: alu_result_sequencer

Overview:
- Downstream consumer of the ALU's 2*BITS-wide operationResult; plays the Z-register role of the datapath.
- Captures the result together with the one-hot op code and latches the HI/LO halves for multiply/divide.
- Serialises the result onto the BITS-wide internal bus with a valid/ready handshake: low half first, then high half only for wide ops.

Parameters:
- BITS, 32, datapath width; the result is 2*BITS.
- SIG_COUNT, 12, width of the one-hot op code (bit 2 = multiply, bit 3 = divide).
- CNT_BITS, 8, width of the completed-operation counter.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- capture_in  in  1  strobe: latch result_in/ctrl_signal this cycle.
- ctrl_signal  in  SIG_COUNT  one-hot op code accompanying the result.
- result_in  in  2*BITS  ALU operationResult.
- in_ready  out  1  block can accept a capture this cycle.
- bus_out  out  BITS  current beat data.
- bus_valid  out  1  bus_out holds a valid beat.
- bus_ready  in  1  bus accepts the beat this cycle.
- beat_high  out  1  current beat is the high half.
- hi_out  out  BITS  HI register (upper half of last mul/div).
- lo_out  out  BITS  LO register (lower half of last mul/div).
- ops_done  out  CNT_BITS  count of fully drained results, wraps.
- op_error  out  1  sticky error flag; only used with ONEHOT_CHECK_EN.

Behaviour:
- Reset (clear=1, asynchronous):
  - state=IDLE; bus_valid=0, beat_high=0, bus_out=0.
  - hi_out=0, lo_out=0, ops_done=0, op_error=0; result register=0.
  - in_ready=1 once clear deasserts.
  - Clear mid-transfer aborts the transfer immediately; the pending beat is lost and ops_done is not incremented.
- States: IDLE, LOW, HIGH.
- in_ready = (state==IDLE) OR (current beat is the last beat AND bus_ready).
- Capture: capture_in && in_ready at a rising edge latches result_in into a 2*BITS register and records wide = ctrl_signal[2] | ctrl_signal[3]. The FSM goes to LOW.
- capture_in && !in_ready: the capture is ignored, with no side effects. The producer must hold its result until in_ready is high.
- Latency: bus_valid rises the cycle after capture.
  - LOW beat: bus_out = result[BITS-1:0], beat_high=0.
  - HIGH beat: bus_out = result[2*BITS-1:BITS], beat_high=1.
- Handshake: a beat transfers on a rising edge with bus_valid && bus_ready. bus_out, bus_valid and beat_high stay stable while bus_ready=0.
- Transitions:
  - IDLE -> LOW on capture.
  - LOW -> HIGH on transfer if wide.
  - LOW -> IDLE on transfer if not wide, or LOW -> LOW if a capture occurs the same edge.
  - HIGH -> IDLE on transfer, or HIGH -> LOW if a capture occurs the same edge.
- Back-to-back: a capture coinciding with the last-beat transfer is accepted, with no bubble. bus_valid stays 1, and the new LOW beat is presented the next cycle.
- HI/LO: on a wide capture, hi_out/lo_out load the upper/lower halves at the capture edge. Non-wide captures leave HI/LO unchanged.
- ops_done: increments by 1 on each last-beat transfer; wraps from 2^CNT_BITS-1 to 0.
- Narrow ops transfer only the low half. The upper half of result_in is ignored for them, except that it is stored.

Optional Feature:
- Macro: ALU_RESULT_ONEHOT_CHECK_EN.
- Defined:
  - A capture whose ctrl_signal is not exactly one-hot (zero, or two or more bits set) is dropped: no state change, no HI/LO update.
  - The same capture sets op_error=1, which is sticky until clear.
- Undefined:
  - No check; op_error is tied to 0.
  - Wide is decided from bits 2|3 alone, and any capture is accepted.

Test Plan:
- Add capture: result_in=64'h0000_0000_0000_0007, ctrl_signal=12'h001, bus_ready=1 -> one beat bus_out=32'h7 with beat_high=0; HI/LO stay 0; ops_done=1.
- Multiply capture: result_in=64'hDEAD_BEEF_1234_5678, ctrl_signal=12'h004, bus_ready=1 -> beats 32'h1234_5678 then 32'hDEAD_BEEF with beat_high=0 then 1; hi_out=32'hDEAD_BEEF and lo_out=32'h1234_5678 from the capture edge.
- Backpressure: divide capture with bus_ready=0 for 5 cycles -> LOW beat held stable, in_ready=0; a capture_in during the stall is ignored; two beats after release.
- Back-to-back: the next add is captured on the same edge as a multiply's HIGH transfer -> no idle cycle; bus_valid stays 1; ops_done increments by 2 over the sequence.
- Reset mid-op: assert clear during a HIGH beat -> bus_valid=0, hi_out=0, ops_done=0 immediately (asynchronous); the next capture proceeds normally.
- With ALU_RESULT_ONEHOT_CHECK_EN: ctrl_signal=12'h005 -> capture dropped, op_error=1, bus_valid stays 0; op_error stays set through subsequent valid ops until clear.
